// File: rtl/vx_perf_pkg.sv
// Shared perf-counter types for the memory-side pipeline counters.
package vx_perf_pkg;

  localparam int PERF_CTR_BITS_DEFAULT = 44;
  localparam int MAX_PENDING_DEFAULT   = 64;

  typedef logic [PERF_CTR_BITS_DEFAULT-1:0] perf_ctr_t;

  typedef struct packed {
    perf_ctr_t ifetches;
    perf_ctr_t loads;
    perf_ctr_t stores;
    perf_ctr_t ifetch_latency;
    perf_ctr_t load_latency;
  } mem_perf_t;

  // {req, rsp} seen by a pending tracker in one cycle
  typedef enum logic [1:0] {
    PEND_IDLE = 2'b00,
    PEND_RSP  = 2'b01,
    PEND_REQ  = 2'b10,
    PEND_BOTH = 2'b11
  } pend_op_t;

endpackage

// File: rtl/vx_mem_perf_tracker_if.sv
// Handshake taps in, perf counters out; master = pipeline side, slave = tracker.
interface vx_mem_perf_tracker_if #(
  parameter int PERF_CTR_BITS = 44,
  parameter int MAX_PENDING   = 64
);
  localparam int PEND_BITS = $clog2(MAX_PENDING + 1);

  logic                     perf_clear;
  logic                     icache_req_fire;
  logic                     icache_rsp_fire;
  logic                     dcache_req_fire;
  logic                     dcache_req_rw;
  logic                     dcache_rsp_fire;

  logic [PERF_CTR_BITS-1:0] ifetches;
  logic [PERF_CTR_BITS-1:0] loads;
  logic [PERF_CTR_BITS-1:0] stores;
  logic [PERF_CTR_BITS-1:0] ifetch_latency;
  logic [PERF_CTR_BITS-1:0] load_latency;
  logic                     pending_err;
  // outstanding-request depth per class, for observability
  logic [PEND_BITS-1:0]     ifetch_pending;
  logic [PEND_BITS-1:0]     load_pending;

  modport master (
    output perf_clear, icache_req_fire, icache_rsp_fire,
           dcache_req_fire, dcache_req_rw, dcache_rsp_fire,
    input  ifetches, loads, stores, ifetch_latency, load_latency,
           pending_err, ifetch_pending, load_pending
  );

  modport slave (
    input  perf_clear, icache_req_fire, icache_rsp_fire,
           dcache_req_fire, dcache_req_rw, dcache_rsp_fire,
    output ifetches, loads, stores, ifetch_latency, load_latency,
           pending_err, ifetch_pending, load_pending
  );

endinterface

// File: rtl/vx_perf_pending_ctr.sv
// Outstanding-request tracker: pending depth, latency sum (Little's law), sticky err. PERF_SATURATE_EN.
// Latency: 1 cycle, registered. Backpressure: none, passive tap; over/underflow only flags err.
module vx_perf_pending_ctr
  import vx_perf_pkg::*;
#(
  parameter int   CTR_BITS    = PERF_CTR_BITS_DEFAULT,
  parameter int   MAX_PENDING = MAX_PENDING_DEFAULT,
  localparam int  PEND_BITS   = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 rsp,
  input  logic                 clear,
  output logic [PEND_BITS-1:0] pending,
  output logic [CTR_BITS-1:0]  latency,
  output logic                 err
);

  pend_op_t             op;
  logic [PEND_BITS-1:0] pending_nxt;
  logic                 err_set;
  logic [CTR_BITS-1:0]  lat_nxt;
  logic [CTR_BITS:0]    lat_sum;

  assign op = pend_op_t'({req, rsp});

  always_comb begin
    pending_nxt = pending;
    err_set     = 1'b0;
    unique case (op)
      PEND_REQ: begin
        if (pending == PEND_BITS'(MAX_PENDING)) err_set = 1'b1;
        else                                    pending_nxt = pending + PEND_BITS'(1);
      end
      PEND_RSP: begin
        if (pending == '0) err_set = 1'b1;
        else               pending_nxt = pending - PEND_BITS'(1);
      end
      default: pending_nxt = pending;
    endcase
  end

  // accumulate depth at cycle start, before this cycle's req/rsp
  assign lat_sum = {1'b0, latency} + (CTR_BITS + 1)'(pending);

  always_comb begin
`ifdef PERF_SATURATE_EN
    lat_nxt = lat_sum[CTR_BITS] ? '1 : lat_sum[CTR_BITS-1:0];
`else
    lat_nxt = lat_sum[CTR_BITS-1:0];
`endif
  end

  // clear wipes the statistics but keeps in-flight depth so responses still balance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      latency <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (clear) begin
        latency <= '0;
        err     <= 1'b0;
      end else begin
        latency <= lat_nxt;
        err     <= err | err_set;
      end
    end
  end

endmodule

// File: rtl/vx_mem_perf_tracker.sv
// Memory-side perf counters (ifetch/load/store counts, latency sums); PERF_SATURATE_EN selects saturation.
// Latency: fire in cycle N visible at outputs in N+1. Backpressure: none, passive handshake tap.
module vx_mem_perf_tracker
  import vx_perf_pkg::*;
#(
  parameter int PERF_CTR_BITS = PERF_CTR_BITS_DEFAULT,
  parameter int MAX_PENDING   = MAX_PENDING_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vx_mem_perf_tracker_if.slave  bus
);

  typedef logic [PERF_CTR_BITS-1:0] ctr_t;

  function automatic ctr_t ctr_inc(ctr_t cur, logic inc);
`ifdef PERF_SATURATE_EN
    return (inc && (cur != '1)) ? cur + ctr_t'(1) : cur;
`else
    return cur + ctr_t'(inc);
`endif
  endfunction

  ctr_t ifetch_cnt;
  ctr_t load_cnt;
  ctr_t store_cnt;
  logic load_fire;
  logic store_fire;
  logic ifetch_err;
  logic load_err;

  assign load_fire  = bus.dcache_req_fire & ~bus.dcache_req_rw;
  assign store_fire = bus.dcache_req_fire &  bus.dcache_req_rw;

  // fires in a clear cycle are dropped, not carried into the fresh count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifetch_cnt <= '0;
      load_cnt   <= '0;
      store_cnt  <= '0;
    end else if (bus.perf_clear) begin
      ifetch_cnt <= '0;
      load_cnt   <= '0;
      store_cnt  <= '0;
    end else begin
      ifetch_cnt <= ctr_inc(ifetch_cnt, bus.icache_req_fire);
      load_cnt   <= ctr_inc(load_cnt,   load_fire);
      store_cnt  <= ctr_inc(store_cnt,  store_fire);
    end
  end

  vx_perf_pending_ctr #(
    .CTR_BITS    (PERF_CTR_BITS),
    .MAX_PENDING (MAX_PENDING)
  ) u_ifetch_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.icache_req_fire),
    .rsp     (bus.icache_rsp_fire),
    .clear   (bus.perf_clear),
    .pending (bus.ifetch_pending),
    .latency (bus.ifetch_latency),
    .err     (ifetch_err)
  );

  // stores never return a response, so only loads are tracked
  vx_perf_pending_ctr #(
    .CTR_BITS    (PERF_CTR_BITS),
    .MAX_PENDING (MAX_PENDING)
  ) u_load_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (load_fire),
    .rsp     (bus.dcache_rsp_fire),
    .clear   (bus.perf_clear),
    .pending (bus.load_pending),
    .latency (bus.load_latency),
    .err     (load_err)
  );

  assign bus.ifetches    = ifetch_cnt;
  assign bus.loads       = load_cnt;
  assign bus.stores      = store_cnt;
  assign bus.pending_err = ifetch_err | load_err;

endmodule

// File: tb/tb_vx_mem_perf_tracker.sv
// Scoreboard bench: stimulus pushes model expectations per cycle, a monitor pops and compares after each edge.
module tb_vx_mem_perf_tracker;
  import vx_perf_pkg::*;

  localparam int     W    = 44;
  localparam int     MAXP = 64;
  localparam longint MASK = (64'sd1 <<< W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  vx_mem_perf_tracker_if #(.PERF_CTR_BITS(W), .MAX_PENDING(MAXP)) bus ();

  vx_mem_perf_tracker #(.PERF_CTR_BITS(W), .MAX_PENDING(MAXP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_perf_t c;
    bit        err;
    int        ip;
    int        lp;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;

  longint m_if, m_ld, m_st, m_il, m_ll;
  int     m_ip, m_lp;
  bit     m_err;

  function automatic longint add(longint a, longint b);
    longint s = a + b;
`ifdef PERF_SATURATE_EN
    return (s > MASK) ? MASK : s;
`else
    return s & MASK;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A tracked class: depth moves by req-rsp, illegal moves hold depth and raise an error.
  task automatic pend_upd(input int p, input bit rq, input bit rs, output int np, output bit e);
    np = p;
    e  = 1'b0;
    if (rq && !rs) begin
      if (p == MAXP) e = 1'b1; else np = p + 1;
    end else if (rs && !rq) begin
      if (p == 0) e = 1'b1; else np = p - 1;
    end
  endtask

  task automatic model_reset();
    m_if = 0; m_ld = 0; m_st = 0; m_il = 0; m_ll = 0;
    m_ip = 0; m_lp = 0; m_err = 1'b0;
  endtask

  task automatic drive(input bit ir, input bit ic, input bit dr, input bit rw,
                       input bit ds, input bit clr);
    int   nip, nlp;
    bit   ei, el;
    exp_t e;
    @(negedge clk);
    bus.icache_req_fire = ir;
    bus.icache_rsp_fire = ic;
    bus.dcache_req_fire = dr;
    bus.dcache_req_rw   = rw;
    bus.dcache_rsp_fire = ds;
    bus.perf_clear      = clr;
    pend_upd(m_ip, ir, ic, nip, ei);
    pend_upd(m_lp, dr && !rw, ds, nlp, el);
    if (clr) begin
      m_if = 0; m_ld = 0; m_st = 0; m_il = 0; m_ll = 0; m_err = 1'b0;
    end else begin
      m_if  = add(m_if, longint'(ir));
      m_ld  = add(m_ld, longint'(dr && !rw));
      m_st  = add(m_st, longint'(dr && rw));
      m_il  = add(m_il, longint'(m_ip));
      m_ll  = add(m_ll, longint'(m_lp));
      m_err = m_err | ei | el;
    end
    m_ip = nip;
    m_lp = nlp;
    e.c.ifetches       = perf_ctr_t'(m_if);
    e.c.loads          = perf_ctr_t'(m_ld);
    e.c.stores         = perf_ctr_t'(m_st);
    e.c.ifetch_latency = perf_ctr_t'(m_il);
    e.c.load_latency   = perf_ctr_t'(m_ll);
    e.err = m_err;
    e.ip  = m_ip;
    e.lp  = m_lp;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: outputs are valid every cycle, so one expectation is consumed per edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ifetches",       longint'(bus.ifetches),       longint'(e.c.ifetches));
      chk("loads",          longint'(bus.loads),          longint'(e.c.loads));
      chk("stores",         longint'(bus.stores),         longint'(e.c.stores));
      chk("ifetch_latency", longint'(bus.ifetch_latency), longint'(e.c.ifetch_latency));
      chk("load_latency",   longint'(bus.load_latency),   longint'(e.c.load_latency));
      chk("pending_err",    longint'(bus.pending_err),    longint'(e.err));
      chk("ifetch_pending", longint'(bus.ifetch_pending), longint'(e.ip));
      chk("load_pending",   longint'(bus.load_pending),   longint'(e.lp));
    end
  end

  initial begin
    bit ir, ic, dr, rw, ds, clr;
    model_reset();

    // reset held with random fires: everything stays zero
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.icache_req_fire = 1'($urandom);
      bus.icache_rsp_fire = 1'($urandom);
      bus.dcache_req_fire = 1'($urandom);
      bus.dcache_req_rw   = 1'($urandom);
      bus.dcache_rsp_fire = 1'($urandom);
      bus.perf_clear      = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_ifetches",    longint'(bus.ifetches),       0);
      chk("rst_loads",       longint'(bus.loads),          0);
      chk("rst_stores",      longint'(bus.stores),         0);
      chk("rst_if_lat",      longint'(bus.ifetch_latency), 0);
      chk("rst_ld_lat",      longint'(bus.load_latency),   0);
      chk("rst_pending_err", longint'(bus.pending_err),    0);
    end
    @(negedge clk);
    bus.icache_req_fire = 1'b0;
    bus.icache_rsp_fire = 1'b0;
    bus.dcache_req_fire = 1'b0;
    bus.dcache_req_rw   = 1'b0;
    bus.dcache_rsp_fire = 1'b0;
    bus.perf_clear      = 1'b0;
    reset_n = 1'b1;
    idle(3);

    // single ifetch: req, three quiet cycles, rsp -> latency 4
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);

    // mixed LSU burst, load responses ten cycles later
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(10);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);
    idle(2);

    // same-cycle req+rsp at depth 2 holds depth
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);

    // underflow sets the sticky error; clear resets stats but keeps in-flight depth
    drive(0, 0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(3);
    drive(0, 0, 0, 0, 1, 0);
    idle(2);

    // preload ifetches to all-ones, then one more request
    @(negedge clk);
    force dut.ifetch_cnt = {W{1'b1}};
    #1;
    release dut.ifetch_cnt;
    m_if = MASK;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic, depth kept under the limit, occasional stray rsp and clear
    for (int i = 0; i < 400; i++) begin
      ir  = ($urandom_range(0, 2) == 0) && (m_ip < MAXP - 4);
      ic  = ($urandom_range(0, 3) == 0);
      dr  = ($urandom_range(0, 2) == 0) && (m_lp < MAXP - 4);
      rw  = 1'($urandom);
      ds  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
      drive(ir, ic, dr, rw, ds, clr);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
